// File: rtl/pipe_inst_fetch_prefetch_pkg.sv
// Shared constants and helpers for the instruction fetch / prefetch slice.
package pipe_inst_fetch_prefetch_pkg;

  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // Fetch addresses are always word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/pipe_inst_fetch_prefetch_if.sv
// Fetch-to-decode stream, redirect and program-loader signals.
interface pipe_inst_fetch_prefetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);

  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              inst_ready;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [31:0]       inst_pc;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;

  modport master (
    input  redirect, redirect_pc, inst_ready, prog_we, prog_addr, prog_data,
    output inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, inst_ready, prog_we, prog_addr, prog_data,
    input  inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/pipe_inst_ram.sv
// Synchronous 1R1W instruction RAM, read-before-write, zero-initialised contents.
module pipe_inst_ram #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Non-blocking read and write on the same edge give old data on an address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_inst_fetch_prefetch.sv
// Fetch PC, credit-based read issue into the instruction RAM and the {pc,inst} prefetch queue.
module pipe_inst_fetch_prefetch
  import pipe_inst_fetch_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = INST_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter string       INIT_FILE  = ""
) (
  input logic                      clk,
  input logic                      rst,
  pipe_inst_fetch_prefetch_if.master bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = PTR_W + 2;

  logic [31:0]       fetch_pc;
  logic [31:0]       inflight_pc;
  logic              inflight;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] fifo_inst [FIFO_DEPTH];
  logic [31:0]       fifo_pc   [FIFO_DEPTH];
  logic [DATA_W-1:0] rdata;
  logic [CRD_W-1:0]  credit;
  logic              pop;
  logic              push;
  logic              issue;

  pipe_inst_ram #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (bus.prog_we),
    .waddr(bus.prog_addr),
    .wdata(bus.prog_data),
    .raddr(fetch_pc[ADDR_W+1:2]),
    .rdata(rdata)
  );

  assign bus.inst_valid = (count != '0);
  assign bus.inst       = bus.inst_valid ? fifo_inst[rptr] : '0;
  assign bus.inst_pc    = bus.inst_valid ? fifo_pc[rptr]   : '0;

  assign pop  = bus.inst_valid & bus.inst_ready;
  assign push = inflight;

  // Slots already claimed: queued entries plus the read landing next edge, less the one leaving.
  always_comb begin
    credit = CRD_W'(count) + CRD_W'(inflight) - CRD_W'(pop);
    issue  = (credit < CRD_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= align_pc(bus.redirect_pc);
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + PC_STEP;
        inflight_pc <= fetch_pc;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (push && !bus.redirect) begin
      fifo_inst[wptr] <= rdata;
      fifo_pc[wptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_pipe_inst_fetch_prefetch.sv
// Directed bench for the instruction fetch / prefetch queue.
module tb_pipe_inst_fetch_prefetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_inst_fetch_prefetch_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  pipe_inst_fetch_prefetch #(
    .ADDR_W    (8),
    .DATA_W    (32),
    .FIFO_DEPTH(4),
    .RESET_PC  (32'h0),
    .INIT_FILE ("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  function automatic logic [31:0] img(input logic [7:0] w);
    return {24'hA50000, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] data);
    check({tag, " valid"}, {31'd0, bus.inst_valid}, 32'd1);
    check({tag, " pc"}, bus.inst_pc, pc);
    check({tag, " inst"}, bus.inst, data);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;

    // Program image loaded through the loader port while held in reset.
    for (int i = 0; i < 256; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 8'(i);
      bus.prog_data = img(8'(i));
      tick();
    end
    bus.prog_we = 1'b0;

    check("reset valid", {31'd0, bus.inst_valid}, 32'd0);
    check("reset inst", bus.inst, 32'h0);
    check("reset inst_pc", bus.inst_pc, 32'h0);
    check("reset fetch_pc", dut.fetch_pc, 32'h0);

    // 1) stream from reset with inst_ready high
    bus.inst_ready = 1'b1;
    rst = 1'b0;
    tick();
    check("t1 edge1 valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    head("t1 w0", 32'h0, img(8'd0));
    for (int k = 1; k < 4; k++) begin
      tick();
      head("t1 stream", 32'(4 * k), img(8'(k)));
    end

    // 2) back-pressure fills the queue, then drains without gaps
    bus.inst_ready = 1'b0;
    reset_dut();
    tick();
    tick();
    head("t2 first", 32'h0, img(8'd0));
    for (int k = 0; k < 8; k++) tick();
    check("t2 count full", 32'(dut.count), 32'd4);
    check("t2 fetch_pc held", dut.fetch_pc, 32'h10);
    head("t2 stable", 32'h0, img(8'd0));
    bus.inst_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      head("t2 drain", 32'(4 * k), img(8'(k)));
    end

    // 3) redirect while full-credit with a read in flight
    bus.inst_ready = 1'b0;
    reset_dut();
    for (int k = 0; k < 10; k++) tick();
    bus.inst_ready = 1'b1;
    tick();
    check("t3 inflight", {31'd0, dut.inflight}, 32'd1);
    check("t3 count", 32'(dut.count), 32'd3);
    head("t3 pre", 32'h4, img(8'd1));
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0083;
    tick();
    bus.redirect = 1'b0;
    check("t3 flush valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    check("t3 gap valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    head("t3 target", 32'h80, img(8'h20));
    tick();
    head("t3 next", 32'h84, img(8'h21));
    tick();
    head("t3 next2", 32'h88, img(8'h22));

    // 4) redirect coincident with a pop of 0x88
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    check("t4 flush valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    check("t4 gap valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    head("t4 target", 32'h40, img(8'h10));
    tick();
    head("t4 next", 32'h44, img(8'h11));

    // 5) word index wraps past the top of memory
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3F8;
    tick();
    bus.redirect = 1'b0;
    tick();
    tick();
    head("t5 3f8", 32'h3F8, img(8'd254));
    tick();
    head("t5 3fc", 32'h3FC, img(8'd255));
    tick();
    head("t5 400", 32'h400, img(8'd0));

    // 6) loader write colliding with the read of word 5
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h14;
    tick();
    bus.redirect  = 1'b0;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 8'd5;
    bus.prog_data = 32'hDEAD_BEEF;
    tick();
    bus.prog_we = 1'b0;
    tick();
    head("t6 old word", 32'h14, img(8'd5));
    tick();
    head("t6 after", 32'h18, img(8'd6));
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h14;
    tick();
    bus.redirect = 1'b0;
    tick();
    tick();
    head("t6 new word", 32'h14, 32'hDEAD_BEEF);

    // asynchronous reset mid-stream
    tick();
    head("t6 pre-rst", 32'h18, img(8'd6));
    rst = 1'b1;
    #1;
    check("t6 rst valid", {31'd0, bus.inst_valid}, 32'd0);
    check("t6 rst inst", bus.inst, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("t6 restart gap", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    head("t6 restart", 32'h0, img(8'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
